ges_dir_decode: RTL and testbench

GES_DIR_DECODE -- requirements
Module: ges_dir_decode

---
 rtl/ges_pkg.sv | 62 ++++++
 rtl/ges_stable_filter.sv | 40 ++++
 rtl/ges_dir_decode.sv | 158 +++++++++++++++
 tb/tb_ges_dir_decode.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ges_pkg.sv
// Shared encodings for the gesture direction decoder: direction codes,
// gesture flag bit positions, FSM states and the candidate classifier.
package ges_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_FWD   = 4;
  localparam int BIT_BWD   = 5;
  localparam int BIT_CW    = 6;
  localparam int BIT_ACW   = 7;

  localparam logic [7:0] DIR_MASK   = 8'((1 << BIT_UP) | (1 << BIT_DOWN) | (1 << BIT_LEFT) | (1 << BIT_RIGHT));
  localparam logic [7:0] PAUSE_MASK = 8'((1 << BIT_FWD) | (1 << BIT_BWD));

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_LOCKOUT = 2'd2
  } ges_state_t;

  typedef enum logic [1:0] {
    GK_NONE  = 2'd0,
    GK_DIR   = 2'd1,
    GK_PAUSE = 2'd2,
    GK_ERR   = 2'd3
  } ges_kind_t;

  // Rotations (b6/b7) and any multi-flag pattern land in GK_ERR.
  function automatic ges_kind_t classify(input logic [7:0] g);
    ges_kind_t k;
    if (g == 8'h00)
      k = GK_NONE;
    else if ($onehot(g & DIR_MASK) && ((g & ~DIR_MASK) == 8'h00))
      k = GK_DIR;
    else if ($onehot(g & PAUSE_MASK) && ((g & ~PAUSE_MASK) == 8'h00))
      k = GK_PAUSE;
    else
      k = GK_ERR;
    return k;
  endfunction

  function automatic logic [1:0] dir_of(input logic [7:0] g);
    logic [1:0] d;
    if (g[BIT_UP])
      d = DIR_UP;
    else if (g[BIT_DOWN])
      d = DIR_DOWN;
    else if (g[BIT_LEFT])
      d = DIR_LEFT;
    else
      d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/ges_stable_filter.sv
// Holds the candidate gesture byte and counts how long it has been steady;
// o_stable strobes on the cycle the candidate has been held long enough.
module ges_stable_filter #(
  parameter int STABLE_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_run,
  input  logic [7:0] i_data,
  output logic [7:0] o_cand,
  output logic       o_stable
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

  logic [7:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic          w_same;

  assign w_same = (i_data == r_cand);

  // The counter saturates at CNT_MAX so a stalled evaluation never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= 8'h00;
      r_cnt  <= '0;
    end else if (i_load || (i_run && !w_same)) begin
      r_cand <= i_data;
      r_cnt  <= '0;
    end else if (i_run && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cand   = r_cand;
  assign o_stable = i_run && w_same && (r_cnt == CNT_MAX);

endmodule

// File: rtl/ges_dir_decode.sv
// Turns debounced gesture flags into direction / pause-toggle commands with a
// valid/ready output, a post-command lockout and error/overrun pulses.
module ges_dir_decode
  import ges_pkg::*;
#(
  parameter int STABLE_CYC  = 50000,
  parameter int LOCKOUT_CYC = 10000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] po_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic       cmd_pause,
  output logic       ges_err,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
  // payload holds while cmd_valid && !cmd_ready unless a newer command
  // overwrites it (overrun pulses); cmd_ready with cmd_valid low is ignored.

  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [LW-1:0] LK_MAX = LW'(LOCKOUT_CYC - 1);

  ges_state_t r_state, w_next;

  logic [7:0]    r_prev;
  logic [1:0]    r_cur_dir;
  logic [LW-1:0] r_lk_cnt;
  logic          r_valid;
  logic [1:0]    r_dir;
  logic          r_pause;
  logic          r_err;
  logic          r_ovr;

  logic          w_load;
  logic          w_run;
  logic [7:0]    w_cand;
  logic          w_stable;
  ges_kind_t     w_kind;
  logic [1:0]    w_dir;
  logic          w_dir_blocked;
  logic          w_lk_done;
  logic          w_take_dir;
  logic          w_take_pause;
  logic          w_err;
  logic          w_accept;

  assign w_load = (r_state == ST_IDLE) && (po_data != r_prev);
  assign w_run  = (r_state == ST_FILTER);

  ges_stable_filter #(
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .i_load   (w_load),
    .i_run    (w_run),
    .i_data   (po_data),
    .o_cand   (w_cand),
    .o_stable (w_stable)
  );

  assign w_kind = classify(w_cand);
  assign w_dir  = dir_of(w_cand);
  // Same axis as the current direction (repeat or reversal) is suppressed.
  assign w_dir_blocked = (w_dir[1] == r_cur_dir[1]);
  assign w_lk_done     = (r_lk_cnt == LK_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_take_dir   = 1'b0;
    w_take_pause = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_next = ST_FILTER;
      end
      ST_FILTER: begin
        if (w_stable) begin
          case (w_kind)
            GK_DIR: begin
              if (w_dir_blocked) begin
                w_next = ST_IDLE;
              end else begin
                w_take_dir = 1'b1;
                w_next     = ST_LOCKOUT;
              end
            end
            GK_PAUSE: begin
              w_take_pause = 1'b1;
              w_next       = ST_LOCKOUT;
            end
            GK_ERR: begin
              w_err  = 1'b1;
              w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
          endcase
        end
      end
      ST_LOCKOUT: begin
        if (w_lk_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_take_dir || w_take_pause;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev    <= 8'h00;
      r_cur_dir <= DIR_RIGHT;
      r_lk_cnt  <= '0;
      r_valid   <= 1'b0;
      r_dir     <= DIR_RIGHT;
      r_pause   <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_err <= w_err;
      r_ovr <= w_accept && r_valid && !cmd_ready;
      if (w_stable) r_prev <= w_cand;
      if (w_take_dir) r_cur_dir <= w_dir;
      if (w_accept)
        r_lk_cnt <= '0;
      else if ((r_state == ST_LOCKOUT) && !w_lk_done)
        r_lk_cnt <= r_lk_cnt + 1'b1;
      // A new command wins over a completing handshake so valid stays high.
      if (w_accept) begin
        r_valid <= 1'b1;
        r_dir   <= w_take_dir ? w_dir : r_cur_dir;
        r_pause <= w_take_pause;
      end else if (r_valid && cmd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign cmd_valid = r_valid;
  assign cmd_dir   = r_dir;
  assign cmd_pause = r_pause;
  assign ges_err   = r_err;
  assign overrun   = r_ovr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ges_dir_decode.sv
// Bench for ges_dir_decode with short filter/lockout windows: directed
// gesture sequences plus a scoreboard of expected command/error/overrun events.
module tb_ges_dir_decode;
  import ges_pkg::*;

  localparam int STABLE  = 4;
  localparam int LOCKOUT = 8;
  localparam int LAT_BUDGET = 20;
  localparam logic [1:0] K_CMD = 2'd0;
  localparam logic [1:0] K_ERR = 2'd1;
  localparam logic [1:0] K_OVR = 2'd2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] po_data = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_pause;
  logic       ges_err;
  logic       overrun;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  logic [4:0] exp_q[$];

  logic       p_valid = 1'b0;
  logic       p_hs = 1'b0;
  logic [1:0] p_dir = 2'b00;
  logic       p_pause = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  ges_dir_decode #(
    .STABLE_CYC  (STABLE),
    .LOCKOUT_CYC (LOCKOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .po_data   (po_data),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_pause (cmd_pause),
    .ges_err   (ges_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // 5'h1F stands for "no event expected".
  task automatic sb_pop(input string tag, input logic [4:0] obs);
    logic [4:0] e;
    if (exp_q.size() == 0)
      e = 5'h1F;
    else
      e = exp_q.pop_front();
    check(tag, 16'(obs), 16'(e));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 16'(cmd_valid), 16'(0));
    check({tag, "_dir"},   16'(cmd_dir),   16'(DIR_RIGHT));
    check({tag, "_pause"}, 16'(cmd_pause), 16'(0));
    check({tag, "_err"},   16'(ges_err),   16'(0));
    check({tag, "_ovr"},   16'(overrun),   16'(0));
    check({tag, "_state"}, 16'(dbg_state), 16'(ST_IDLE));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      p_valid = 1'b0;
      p_hs    = 1'b0;
    end else begin
      if (ges_err) sb_pop("ges_err_event", {K_ERR, 3'b000});
      if (overrun) sb_pop("overrun_event", {K_OVR, cmd_dir, cmd_pause});
      if (cmd_valid && (!p_valid || p_hs || overrun))
        sb_pop("cmd_event", {K_CMD, cmd_dir, cmd_pause});
      if (p_valid && !p_hs) begin
        check("valid_hold", 16'(cmd_valid), 16'(1));
        if (cmd_valid && !overrun)
          check("payload_hold", 16'({cmd_dir, cmd_pause}), 16'({p_dir, p_pause}));
      end
      p_valid = cmd_valid;
      p_hs    = cmd_valid && cmd_ready;
      p_dir   = cmd_dir;
      p_pause = cmd_pause;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_po(input logic [7:0] v);
    @(posedge sys_clk);
    #1 po_data = v;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Cycles from the change until cmd_valid (or overrun) is first seen.
  task automatic set_po_timed(input logic [7:0] v, input bit use_ovr, output int lat);
    @(posedge sys_clk);
    #1 po_data = v;
    lat = 0;
    while (lat < LAT_BUDGET) begin
      @(posedge sys_clk);
      #1;
      lat++;
      if (use_ovr ? overrun : cmd_valid) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int lk_n;

    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset("rst");
    sys_rst_n = 1'b1;
    cmd_ready = 1'b1;

    // Left with cur_dir=right: same axis, silently dropped.
    set_po(8'h04);
    idle_wait(12);
    check("left_filtered_state", 16'(dbg_state), 16'(ST_IDLE));
    check("left_filtered_valid", 16'(cmd_valid), 16'(0));
    set_po(8'h00);
    idle_wait(10);

    // Up: latency, payload, one-cycle valid, lockout length, no retrigger.
    exp_q.push_back({K_CMD, DIR_UP, 1'b0});
    set_po_timed(8'h01, 1'b0, lat);
    check("lat_up", 16'(lat), 16'(STABLE + 1));
    check("dir_up", 16'(cmd_dir), 16'(DIR_UP));
    check("pause_up", 16'(cmd_pause), 16'(0));
    lk_n = (dbg_state == ST_LOCKOUT) ? 1 : 0;
    @(posedge sys_clk);
    #1;
    check("valid_pulse", 16'(cmd_valid), 16'(0));
    for (int i = 0; i < 30 && dbg_state == ST_LOCKOUT; i++) begin
      lk_n++;
      @(posedge sys_clk);
      #1;
    end
    check("lockout_len", 16'(lk_n), 16'(LOCKOUT));
    idle_wait(10);
    check("no_retrigger", 16'(dbg_state), 16'(ST_IDLE));

    // Invalid patterns.
    exp_q.push_back({K_ERR, 3'b000});
    set_po(8'h05);
    idle_wait(10);
    exp_q.push_back({K_ERR, 3'b000});
    set_po(8'h40);
    idle_wait(10);
    check("err_valid_low", 16'(cmd_valid), 16'(0));
    set_po(8'h00);
    idle_wait(10);

    // Left now accepted (cur_dir=up).
    exp_q.push_back({K_CMD, DIR_LEFT, 1'b0});
    set_po_timed(8'h04, 1'b0, lat);
    check("lat_left", 16'(lat), 16'(STABLE + 1));
    idle_wait(14);

    // Glitch restarts the filter.
    exp_q.push_back({K_CMD, DIR_DOWN, 1'b0});
    set_po(8'h02);
    @(posedge sys_clk);
    set_po(8'h00);
    set_po_timed(8'h02, 1'b0, lat);
    check("lat_glitch", 16'(lat), 16'(STABLE + 1));
    check("dir_down", 16'(cmd_dir), 16'(DIR_DOWN));
    idle_wait(14);

    exp_q.push_back({K_CMD, DIR_RIGHT, 1'b0});
    set_po(8'h08);
    idle_wait(16);

    // Overrun: consumer stalled, pause replaces a pending up command.
    cmd_ready = 1'b0;
    set_po(8'h00);
    idle_wait(10);
    exp_q.push_back({K_CMD, DIR_UP, 1'b0});
    set_po_timed(8'h01, 1'b0, lat);
    check("lat_pending", 16'(lat), 16'(STABLE + 1));
    idle_wait(14);
    check("pending_held", 16'(cmd_valid), 16'(1));
    set_po(8'h00);
    idle_wait(10);
    exp_q.push_back({K_OVR, DIR_UP, 1'b1});
    exp_q.push_back({K_CMD, DIR_UP, 1'b1});
    set_po_timed(8'h10, 1'b1, lat);
    check("lat_overrun", 16'(lat), 16'(STABLE + 1));
    check("ovr_dir", 16'(cmd_dir), 16'(DIR_UP));
    check("ovr_pause", 16'(cmd_pause), 16'(1));
    check("ovr_valid", 16'(cmd_valid), 16'(1));

    // Reset mid-lockout with a command pending.
    idle_wait(2);
    check("pre_reset_state", 16'(dbg_state), 16'(ST_LOCKOUT));
    sys_rst_n = 1'b0;
    po_data = 8'h08;
    #1;
    check_reset("mid_lockout");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("regesture_state", 16'(dbg_state), 16'(ST_FILTER));
    idle_wait(12);
    check("right_filtered_state", 16'(dbg_state), 16'(ST_IDLE));
    check("right_filtered_valid", 16'(cmd_valid), 16'(0));

    check("queue_empty", 16'(exp_q.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
